// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - handshake bundle between adder, result stage and Z register
// Purpose: carries the upstream adder result stream and the downstream buffered result.
// Signals:
//   in_valid/in_ready   upstream handshake
//   sum, co             adder sum and carry-out
//   a_msb, b_msb        operand sign bits as presented to the adder
//   out_valid/out_ready downstream handshake
//   z_out               buffered result
//   flag_z/n/c/v        zero, negative, carry, overflow flags of z_out
// Modports: slave = result stage, master = surrounding environment.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z_out;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport slave (
    input  in_valid, sum, co, a_msb, b_msb, out_ready,
    output in_ready, out_valid, z_out, flag_z, flag_n, flag_c, flag_v
  );

  modport master (
    output in_valid, sum, co, a_msb, b_msb, out_ready,
    input  in_ready, out_valid, z_out, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry result buffer with flag generation between adder and Z register
// Purpose: buffers adder results with zero/negative/carry (and optional overflow) flags
//   computed at push time; delivers them in order to the downstream consumer.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    alu_result_stage_if.slave (input stream, output stream, flags)
// Parameters: WIDTH result width; DEPTH buffer entries (only 2 supported).
// Optional feature: define ALU_RESULT_OVF_EN to compute and store flag_v;
//   otherwise flag_v is tied to 0 and a_msb/b_msb are ignored.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_result_stage_if.slave bus
);

  logic [WIDTH-1:0] sum_q [DEPTH];
  logic             z_q   [DEPTH];
  logic             n_q   [DEPTH];
  logic             c_q   [DEPTH];
`ifdef ALU_RESULT_OVF_EN
  logic             v_q   [DEPTH];
  logic             v_in;
`endif

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Both handshake outputs come straight from the occupancy register, so
  // out_ready never reaches in_ready combinationally. A full buffer refuses
  // a push even when it is being popped in the same cycle.
  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

`ifdef ALU_RESULT_OVF_EN
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign v_in = (bus.a_msb == bus.b_msb) && (bus.sum[WIDTH-1] != bus.a_msb);
`else
  logic unused_msbs;
  assign unused_msbs = bus.a_msb ^ bus.b_msb;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        sum_q[i] <= '0;
        z_q[i]   <= 1'b0;
        n_q[i]   <= 1'b0;
        c_q[i]   <= 1'b0;
`ifdef ALU_RESULT_OVF_EN
        v_q[i]   <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        sum_q[wr_ptr] <= bus.sum;
        // Zero flag looks only at the sum; the carry-out is kept separately.
        z_q[wr_ptr]   <= (bus.sum == '0);
        n_q[wr_ptr]   <= bus.sum[WIDTH-1];
        c_q[wr_ptr]   <= bus.co;
`ifdef ALU_RESULT_OVF_EN
        v_q[wr_ptr]   <= v_in;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are forced to zero whenever nothing is buffered so a consumer
  // never sees a stale entry.
  always_comb begin
    bus.z_out  = '0;
    bus.flag_z = 1'b0;
    bus.flag_n = 1'b0;
    bus.flag_c = 1'b0;
    bus.flag_v = 1'b0;
    if (bus.out_valid) begin
      bus.z_out  = sum_q[rd_ptr];
      bus.flag_z = z_q[rd_ptr];
      bus.flag_n = n_q[rd_ptr];
      bus.flag_c = c_q[rd_ptr];
`ifdef ALU_RESULT_OVF_EN
      bus.flag_v = v_q[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage
module tb_alu_result_stage;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic [3:0]       flags;  // {z, n, c, v}
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t q[$];

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drives one vector for one cycle; called and returns at posedge+1.
  task automatic send(input logic [WIDTH-1:0] s, input logic c, input logic am, input logic bm,
                      input logic acc, input logic ez, input logic en, input logic ec,
                      input logic ev);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.sum      = s;
    bus.co       = c;
    bus.a_msb    = am;
    bus.b_msb    = bm;
    check_bit("in_ready", bus.in_ready, acc);
    e.z = s;
`ifdef ALU_RESULT_OVF_EN
    e.flags = {ez, en, ec, ev};
`else
    e.flags = {ez, en, ec, 1'b0};
`endif
    @(posedge clk);
    if (acc) q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares the presented head against the scoreboard every cycle,
  // so a stalled head must match the same expected entry until it is taken.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got z_out=%h expected no output at %0t", bus.z_out, $time);
      end else begin
        checks++;
        if (bus.z_out !== q[0].z) begin
          errors++;
          $display("FAIL z_out: got %h expected %h at %0t", bus.z_out, q[0].z, $time);
        end
        checks++;
        if ({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== q[0].flags) begin
          errors++;
          $display("FAIL flags: got %b expected %b at %0t",
                   {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, q[0].flags, $time);
        end
        if (bus.out_ready === 1'b1) void'(q.pop_front());
      end
    end else begin
      checks++;
      if ({bus.z_out, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== '0) begin
        errors++;
        $display("FAIL idle_zero: got z_out=%h flags=%b expected all zero at %0t",
                 bus.z_out, {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, $time);
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL missing_output: got out_valid=%b expected 1 (%0d pending) at %0t",
                 bus.out_valid, q.size(), $time);
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sum       = '0;
    bus.co        = 1'b0;
    bus.a_msb     = 1'b0;
    bus.b_msb     = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    check_bit("reset_in_ready", bus.in_ready, 1'b1);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);

    // Single push, immediate drain; count=0 with out_ready=1 does nothing.
    send(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 0xFFFFFFFF + 1: zero and carry, not negative, no overflow.
    send(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Stall: third value refused, head holds 1, then drains 1, 2.
    bus.out_ready = 1'b0;
    send(32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_bit("full_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    idle(3);

    // Full with pop in the same cycle: push refused, in_ready rises next cycle.
    bus.out_ready = 1'b0;
    send(32'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    send(32'd22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd23, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Steady stream 10..17: every push accepted, one output per cycle.
    for (int i = 0; i < 8; i++) begin
      send(32'(10 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_bit("stream_out_valid", bus.out_valid, 1'b1);
    end
    idle(3);

    // Overflow cases: 0x7FFFFFFF+1 and 0x80000000+0xFFFFFFFF.
    send(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    // No overflow: unlike signs, negative result.
    send(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Mid-operation reset with push and pop attempted in the same cycle.
    bus.out_ready = 1'b0;
    send(32'd40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'd41, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum       = 32'd99;
    @(posedge clk);
    q.delete();
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check_bit("post_reset_in_ready", bus.in_ready, 1'b1);
    check_bit("post_reset_out_valid", bus.out_valid, 1'b0);
    idle(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
